axi_lat_monitor: RTL and testbench
==================================

// Module: axi_lat_monitor
// PURPOSE
//  Passive AXI latency monitor for the cust_afu measurement path; successor to the single-shot delay counter.
//  Snoops one AXI read (AR/R) or write (AW/B) channel pair, selected by mode.
//  Timestamps each accepted request per ID and reports total/first-response cycles plus min/max/sum per-request latency.
//  Sits beside the AFU AXI master; results are read by CSR logic after done.
// PARAMETERS
//  ID_W    4   monitored ID bits (low bits of arid/awid/rid/bid); table depth NUM_ID = 2**ID_W
//  CNT_W   32  timestamp/latency width; lat_sum is 64b
//  HIST_B  8   histogram bins (LAT_HIST_EN only)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       synchronous active-low reset
//  start        in   1       clear all stats and arm (1-cycle pulse)
//  mode         in   1       0=read (AR/R, completes on rlast), 1=write (AW/B); sampled at start
//  num_request  in   32      responses expected before done
//  arvalid/arready, rvalid/rready/rlast, awvalid/awready, bvalid/bready  in 1 each  snooped handshakes
//  arid, rid, awid, bid  in  12  IDs; only [ID_W-1:0] used
//  busy         out  1       ARMED or RUN
//  done         out  1       DONE state
//  req_cnt      out  32      accepted requests
//  rsp_cnt      out  32      completed responses
//  total_cyc    out  CNT_W   first accepted request -> last completing response
//  first_cyc    out  CNT_W   first accepted request -> first completing response
//  lat_min      out  CNT_W   min per-request latency (all-ones until first sample)
//  lat_max      out  CNT_W   max per-request latency
//  lat_sum      out  64      sum of per-request latencies (wraps)
//  overlap_err  out  1       sticky: request on ID already outstanding
//  orphan_err   out  1       sticky: response on ID with nothing outstanding
//  hist         out  HIST_B*32  bin counters, bin k at [32k+:32] (LAT_HIST_EN only)
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except lat_min=all-ones; table valid bits cleared.
//  FSM: IDLE -start-> ARMED; ARMED -first req handshake-> RUN; RUN -rsp_cnt reaches num_request-> DONE.
//   start in any state: clear all stats/table/errors, go ARMED next cycle. num_request==0: ARMED->DONE next cycle.
//  Request = (mode? awvalid&awready : arvalid&arready). Response = (mode? bvalid&bready : rvalid&rready&rlast).
//  now: free-running CNT_W counter, cleared on start; wraps; latency = now - ts[id] modulo 2**CNT_W.
//  Request: req_cnt++; if !vld[id] store ts[id]=now, vld[id]=1; else set overlap_err, keep older ts.
//  Response: if vld[id]: rsp_cnt++, clear vld[id], update min/max/sum (1-cycle registered update); else orphan_err, no stats.
//  Same cycle request+response on same ID: response retires old entry using old ts, request installs new ts.
//  total_cyc counts every cycle in RUN incl. the cycle of the final response; first_cyc stops after first response.
//  Requests/responses in IDLE or DONE ignored; responses in ARMED flagged orphan.
//  Counters saturate only at 2**32-1 (req_cnt, rsp_cnt); latency arithmetic wraps.
//  done asserted cycle after final response handshake; stats stable until next start.
//  Reset mid-run: immediate return to IDLE, all stats lost.
// CONFIGURATION
//  `LAT_HIST_EN defined: per-response bin = min(floor(log2(lat)), HIST_B-1), lat 0/1 -> bin 0; 32b saturating bins, cleared on start.
//  Not defined: no histogram logic; hist port tied to 0.
// TESTING
//  mode=0, num_request=1, AR id 3 at t, R rlast id 3 at t+40 -> lat_min=lat_max=lat_sum=40, first_cyc=total_cyc=41, done.
//  mode=1, 16 AW ids 0..15 back-to-back, B out of order 20..35 cycles later -> req=rsp=16, lat_min/max exact, no errors.
//  Second AR id 5 while id 5 outstanding -> overlap_err=1, first ts kept; B/R with idle id -> orphan_err=1, rsp_cnt unchanged.
//  Same-cycle R(id 2, rlast) and AR(id 2) -> old latency recorded, new entry valid, vld[2]=1.
//  start pulsed mid-RUN -> all stats cleared, ARMED next cycle; reset_n low mid-RUN -> IDLE, outputs at reset values.
//  LAT_HIST_EN: latencies 1,5,300 -> bins 0,2,7 each = 1 (HIST_B=8).

Source files
------------

// File: rtl/axi_lat_monitor.sv
// ---------------------------------------------------------------------------
// axi_lat_monitor
//
// Passive latency monitor for one AXI channel pair. Snoops either the read
// path (AR -> R with rlast) or the write path (AW -> B), chosen by mode when
// start is pulsed. Every accepted request is timestamped in a per-ID table.
// A matching completion retires the entry and feeds min/max/sum latency
// statistics. Results stay stable in DONE until the next start.
//
// Optional feature: define LAT_HIST_EN to build a log2 latency histogram.
// Without it, hist is tied to zero.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   start                 clear all statistics and arm (1-cycle pulse)
//   mode                  0 = read (AR/R), 1 = write (AW/B); sampled at start
//   num_request           completed responses expected before done
//   ar*/r*/aw*/b*         snooped handshakes and IDs (low ID_W bits used)
//   busy, done            ARMED or RUN / DONE state
//   req_cnt, rsp_cnt      accepted requests / completed responses (saturating)
//   total_cyc, first_cyc  first request -> last / first completing response
//   lat_min/max/sum       per-request latency statistics
//   overlap_err           sticky: request on an ID that is already outstanding
//   orphan_err            sticky: response on an ID with nothing outstanding
//   hist                  HIST_B x 32-bit bins, bin k at [32k +: 32]
// ---------------------------------------------------------------------------
module axi_lat_monitor #(
    parameter int ID_W   = 4,
    parameter int CNT_W  = 32,
    parameter int HIST_B = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          num_request,
    input  logic                 arvalid,
    input  logic                 arready,
    input  logic [11:0]          arid,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic                 rlast,
    input  logic [11:0]          rid,
    input  logic                 awvalid,
    input  logic                 awready,
    input  logic [11:0]          awid,
    input  logic                 bvalid,
    input  logic                 bready,
    input  logic [11:0]          bid,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          req_cnt,
    output logic [31:0]          rsp_cnt,
    output logic [CNT_W-1:0]     total_cyc,
    output logic [CNT_W-1:0]     first_cyc,
    output logic [CNT_W-1:0]     lat_min,
    output logic [CNT_W-1:0]     lat_max,
    output logic [63:0]          lat_sum,
    output logic                 overlap_err,
    output logic                 orphan_err,
    output logic [HIST_B*32-1:0] hist
);
    localparam int NUM_ID = 2 ** ID_W;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               mode_q;
    logic [CNT_W-1:0]   now;
    logic [CNT_W-1:0]   ts [NUM_ID];
    logic [NUM_ID-1:0]  vld, vld_ret, vld_nxt;
    logic               first_seen;

    logic               req_hs, rsp_hs;
    logic [ID_W-1:0]    req_id, rsp_id;
    logic               armed_go, live;
    logic               req_take, req_overlap, rsp_hit, rsp_orphan;
    logic [CNT_W-1:0]   lat;
    logic [31:0]        rsp_cnt_inc;

    // Upper ID bits are outside the monitored range.
    logic unused_id_bits;
    assign unused_id_bits = ^{arid[11:ID_W], rid[11:ID_W], awid[11:ID_W], bid[11:ID_W]};

    assign req_hs = mode_q ? (awvalid & awready) : (arvalid & arready);
    assign rsp_hs = mode_q ? (bvalid & bready)   : (rvalid & rready & rlast);
    assign req_id = mode_q ? awid[ID_W-1:0] : arid[ID_W-1:0];
    assign rsp_id = mode_q ? bid[ID_W-1:0]  : rid[ID_W-1:0];

    // An ARMED monitor with nothing to wait for drops straight to DONE, so it
    // neither records traffic nor flags errors on the way.
    assign armed_go    = (state == ARMED) && (num_request != '0);
    assign live        = (state == RUN) || armed_go;
    assign req_take    = req_hs && live;
    assign rsp_hit     = rsp_hs && (state == RUN) && vld[rsp_id];
    assign rsp_orphan  = rsp_hs && live && !rsp_hit;
    assign lat         = now - ts[rsp_id];
    assign rsp_cnt_inc = (rsp_cnt == '1) ? rsp_cnt : rsp_cnt + 32'd1;

    // A response retires its entry before a same-cycle request on that ID is
    // considered, so the pair counts as retire-then-install, not an overlap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        vld_ret = vld;
        if (rsp_hit) vld_ret[rsp_id] = 1'b0;
        vld_nxt = vld_ret;
        if (req_take) vld_nxt[req_id] = 1'b1;
    end
    assign req_overlap = req_take && vld_ret[req_id];

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED:   if (num_request == '0) state_nxt = DONE;
                         else if (req_hs)       state_nxt = RUN;
                RUN:     if (rsp_hit && rsp_cnt_inc >= num_request) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    assign busy = (state == ARMED) || (state == RUN);
    assign done = (state == DONE);

    // NOTE: the timestamp table is deliberately not reset; vld guards every
    // read, so clearing the valid bits is enough and keeps the array as RAM.
    always_ff @(posedge clk) begin
        if (req_take && !req_overlap) ts[req_id] <= now;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset_n || start) begin
            mode_q      <= reset_n & mode;
            now         <= '0;
            vld         <= '0;
            first_seen  <= 1'b0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            total_cyc   <= '0;
            first_cyc   <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            lat_sum     <= '0;
            overlap_err <= 1'b0;
            orphan_err  <= 1'b0;
        end else begin
            now <= now + 1'b1;
            vld <= vld_nxt;
            if (req_take && req_cnt != '1) req_cnt <= req_cnt + 32'd1;
            if (req_overlap) overlap_err <= 1'b1;
            if (rsp_orphan)  orphan_err  <= 1'b1;
            if (rsp_hit) begin
                rsp_cnt    <= rsp_cnt_inc;
                lat_sum    <= lat_sum + 64'(lat);
                first_seen <= 1'b1;
                if (lat < lat_min) lat_min <= lat;
                if (lat > lat_max) lat_max <= lat;
            end
            // Span starts on the first accepted request and runs through the
            // cycle of the final response; first_cyc freezes after the first.
            if ((state == RUN) || (armed_go && req_hs)) begin
                total_cyc <= total_cyc + 1'b1;
                if (!first_seen) first_cyc <= first_cyc + 1'b1;
            end
        end
    end

`ifdef LAT_HIST_EN
    localparam int BIN_W = (HIST_B > 1) ? $clog2(HIST_B) : 1;

    logic [31:0]      bins [HIST_B];
    logic [BIN_W-1:0] bin_idx;

    // Bin = floor(log2(lat)) clamped to the top bin; 0 and 1 land in bin 0.
    always_comb begin
        bin_idx = '0;
        for (int b = 1; b < CNT_W; b++) begin
            if (lat[b]) bin_idx = (b >= HIST_B - 1) ? BIN_W'(HIST_B - 1) : BIN_W'(b);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || start) begin
            for (int k = 0; k < HIST_B; k++) bins[k] <= '0;
        end else if (rsp_hit && bins[bin_idx] != '1) begin
            bins[bin_idx] <= bins[bin_idx] + 32'd1;
        end
    end

    for (genvar g = 0; g < HIST_B; g++) begin : g_hist
        assign hist[32*g +: 32] = bins[g];
    end
`else
    assign hist = '0;
`endif

endmodule

// File: tb/tb_axi_lat_monitor.sv
// Directed bench for axi_lat_monitor: a transaction-level model (outstanding
// map keyed by ID, cycle-stamped spans) is compared with the DUT on every
// cycle, and hand-computed literals pin the model on each scenario.
module tb_axi_lat_monitor;
    logic        clk = 1'b0;
    logic        reset_n, start, mode;
    logic [31:0] num_request;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, bvalid, bready;
    logic [11:0] arid, rid, awid, bid;
    logic        busy, done, overlap_err, orphan_err;
    logic [31:0] req_cnt, rsp_cnt, total_cyc, first_cyc, lat_min, lat_max;
    logic [63:0] lat_sum;
    logic [255:0] hist;

    axi_lat_monitor dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .num_request(num_request),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .busy(busy), .done(done), .req_cnt(req_cnt), .rsp_cnt(rsp_cnt),
        .total_cyc(total_cyc), .first_cyc(first_cyc),
        .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
        .overlap_err(overlap_err), .orphan_err(orphan_err), .hist(hist)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    longint      cyc = 0;            // index of the cycle ending at this posedge
    longint      m_base = 0;         // cycle index where the timestamp clock reads 0
    longint      t_first_req = 0, t_first_rsp = 0;
    bit          m_first_seen = 0, m_mode = 0;
    bit [31:0]   m_ts [int];         // outstanding requests: id -> timestamp
    bit [31:0]   m_req = 0, m_rsp = 0, m_total = 0, m_first = 0;
    bit [31:0]   m_min = '1, m_max = 0;
    bit [63:0]   m_sum = 0;
    bit          m_ovl = 0, m_orph = 0;

    function void m_clear();
        m_ts.delete();
        m_req = 0; m_rsp = 0; m_total = 0; m_first = 0;
        m_min = '1; m_max = 0; m_sum = 0; m_ovl = 0; m_orph = 0;
        m_first_seen = 0;
    endfunction

    always @(posedge clk) begin
        bit        rq, rs, hit;
        int        rqid, rsid;
        bit [31:0] now, lat;
        rq   = m_mode ? (awvalid && awready) : (arvalid && arready);
        rs   = m_mode ? (bvalid && bready)   : (rvalid && rready && rlast);
        rqid = m_mode ? int'(awid[3:0]) : int'(arid[3:0]);
        rsid = m_mode ? int'(bid[3:0])  : int'(rid[3:0]);
        hit  = 0;
        if (!reset_n) begin
            m_clear(); m_phase = M_IDLE; m_mode = 0;
        end else if (start) begin
            m_clear(); m_phase = M_ARMED; m_mode = mode; m_base = cyc + 1;
        end else if (m_phase == M_ARMED && num_request == 0) begin
            m_phase = M_DONE;
        end else if (m_phase == M_ARMED || m_phase == M_RUN) begin
            now = 32'(cyc - m_base);
            if (rs) begin
                if (m_phase == M_RUN && m_ts.exists(rsid)) begin
                    lat = now - m_ts[rsid];
                    m_ts.delete(rsid);
                    hit = 1;
                    if (m_rsp != '1) m_rsp++;
                    m_sum += 64'(lat);
                    if (lat < m_min) m_min = lat;
                    if (lat > m_max) m_max = lat;
                    if (!m_first_seen) begin m_first_seen = 1; t_first_rsp = cyc; end
                end else begin
                    m_orph = 1;
                end
            end
            if (rq) begin
                if (m_phase == M_ARMED) begin m_phase = M_RUN; t_first_req = cyc; end
                if (m_req != '1) m_req++;
                if (m_ts.exists(rqid)) m_ovl = 1;
                else m_ts[rqid] = now;
            end
            if (m_phase == M_RUN) begin
                m_total = 32'(cyc - t_first_req + 1);
                m_first = m_first_seen ? 32'(t_first_rsp - t_first_req + 1) : m_total;
            end
            if (hit && m_rsp >= num_request) m_phase = M_DONE;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",        busy,        (m_phase == M_ARMED || m_phase == M_RUN));
            check("done",        done,        (m_phase == M_DONE));
            check("req_cnt",     req_cnt,     m_req);
            check("rsp_cnt",     rsp_cnt,     m_rsp);
            check("total_cyc",   total_cyc,   m_total);
            check("first_cyc",   first_cyc,   m_first);
            check("lat_min",     lat_min,     m_min);
            check("lat_max",     lat_max,     m_max);
            check("lat_sum",     lat_sum,     m_sum);
            check("overlap_err", overlap_err, m_ovl);
            check("orphan_err",  orphan_err,  m_orph);
`ifndef LAT_HIST_EN
            check("hist_zero",   (hist == '0), 1'b1);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        start = 0; arvalid = 0; rvalid = 0; rlast = 0; awvalid = 0; bvalid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_ar(input int id);
        arvalid = 1; arready = 1; arid = 12'(id);
    endtask

    task automatic drive_r(input int id, input bit last);
        rvalid = 1; rready = 1; rid = 12'(id); rlast = last;
    endtask

    task automatic arm(input bit m, input int n);
        mode = m; num_request = 32'(n); start = 1; tick();
    endtask

    int p [16] = '{14, 12, 10, 8, 6, 4, 2, 0, 15, 13, 11, 9, 7, 5, 3, 1};

    initial begin
        reset_n = 0; start = 0; mode = 0; num_request = 0;
        arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
        awvalid = 0; awready = 0; bvalid = 0; bready = 0;
        arid = 0; rid = 0; awid = 0; bid = 0;
        idle(2);
        cmp_en = 1;
        check("rst_busy", busy, 0);
        check("rst_lat_min", lat_min, 32'hFFFF_FFFF);
        check("rst_lat_sum", lat_sum, 0);
        reset_n = 1;
        idle(2);

        // Single read, 40-cycle latency, with a non-last beat in between.
        arm(0, 1);
        idle(2);
        drive_ar(3); tick();
        idle(19);
        drive_r(3, 0); tick();
        idle(19);
        drive_r(3, 1); tick();
        check("t1_done", done, 1);
        check("t1_lat_min", lat_min, 40);
        check("t1_lat_max", lat_max, 40);
        check("t1_lat_sum", lat_sum, 40);
        check("t1_first_cyc", first_cyc, 41);
        check("t1_total_cyc", total_cyc, 41);

        // 16 back-to-back writes, B out of order with latencies 20..35.
        arm(1, 16);
        for (int k = 0; k < 44; k++) begin
            if (k < 16) begin awvalid = 1; awready = 1; awid = 12'(k); end
            for (int i = 0; i < 16; i++)
                if (i + 20 + p[i] == k) begin bvalid = 1; bready = 1; bid = 12'(i); end
            tick();
        end
        check("t2_req", req_cnt, 16);
        check("t2_rsp", rsp_cnt, 16);
        check("t2_lat_min", lat_min, 20);
        check("t2_lat_max", lat_max, 35);
        check("t2_lat_sum", lat_sum, 440);
        check("t2_first_cyc", first_cyc, 28);
        check("t2_total_cyc", total_cyc, 44);
        check("t2_errs", {overlap_err, orphan_err}, 0);

        // Overlap on ID 5 keeps the first timestamp; orphan response on ID 9.
        arm(0, 2);
        drive_ar(5); tick();
        idle(2);
        drive_ar(5); tick();
        idle(1);
        drive_r(9, 1); tick();
        idle(4);
        drive_r(5, 1); tick();
        check("t3_overlap", overlap_err, 1);
        check("t3_orphan", orphan_err, 1);
        check("t3_rsp", rsp_cnt, 1);
        check("t3_req", req_cnt, 2);
        check("t3_lat_min", lat_min, 10);

        // Same-cycle retire and re-issue on ID 2.
        arm(0, 2);
        drive_ar(2); tick();
        idle(7);
        drive_ar(2); drive_r(2, 1); tick();
        idle(5);
        drive_r(2, 1); tick();
        check("t4_done", done, 1);
        check("t4_lat_min", lat_min, 6);
        check("t4_lat_max", lat_max, 8);
        check("t4_lat_sum", lat_sum, 14);
        check("t4_errs", {overlap_err, orphan_err}, 0);

        // start mid-RUN wipes stats and the outstanding table.
        arm(0, 4);
        drive_ar(1); tick();
        idle(3);
        start = 1; tick();
        check("t5_busy", busy, 1);
        check("t5_req", req_cnt, 0);
        check("t5_lat_min", lat_min, 32'hFFFF_FFFF);
        drive_ar(1); tick();
        idle(2);
        drive_r(1, 1); tick();
        check("t5_lat", lat_min, 3);
        check("t5_overlap", overlap_err, 0);

        // Reset mid-RUN, then traffic in IDLE is ignored.
        reset_n = 0; tick();
        reset_n = 1;
        check("t6_busy", busy, 0);
        check("t6_req", req_cnt, 0);
        check("t6_lat_min", lat_min, 32'hFFFF_FFFF);
        drive_r(1, 1); tick();
        check("t6_orphan", orphan_err, 0);

        // num_request == 0: ARMED then DONE.
        arm(0, 0);
        check("t7_armed", busy, 1);
        tick();
        check("t7_done", done, 1);

`ifdef LAT_HIST_EN
        arm(0, 3);
        for (int k = 0; k < 303; k++) begin
            if (k < 3) drive_ar(k);
            if (k == 1)   drive_r(0, 1);
            if (k == 6)   drive_r(1, 1);
            if (k == 302) drive_r(2, 1);
            tick();
        end
        check("h_bin0", hist[0 +: 32], 1);
        check("h_bin2", hist[64 +: 32], 1);
        check("h_bin7", hist[224 +: 32], 1);
        check("h_bin1", hist[32 +: 32], 0);
`endif

        idle(2);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
